// File: rtl/lcd_msg_scheduler.sv
// LCD message-select scheduler.
// Up to four requesters post display requests. The highest pending code is granted,
// an update strobe is issued, and the block waits for frame completion. It then holds
// the screen for a minimum time, and only a higher-priority request may cut that short.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | nothing on hold; grant the highest pending code if any
// S_LOAD  | one cycle after a grant; oUPD is high, counter cleared
// S_WAIT  | waiting for iLCD_DONE; times out after TIMEOUT_CYCLES
// S_HOLD  | minimum display time; preempted only by a higher code
module lcd_msg_scheduler #(
  parameter int HOLD_CYCLES    = 50000000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 26
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [3:0] iREQ,
  input  logic       iLCD_DONE,
  output logic [1:0] oMESG,
  output logic       oUPD,
  output logic       oBUSY,
  output logic       oTMO
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_pend;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mesg;
  logic             r_upd;
  logic             r_tmo;

  logic [1:0]       w_win;
  logic [3:0]       w_above;
  logic             w_preempt;
  logic             w_grant;
  logic             w_hold_tc;
  logic             w_tmo_tc;
  logic [3:0]       w_clr;
  logic [CNT_W-1:0] w_cnt_nx;

  assign w_hold_tc = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
  assign w_tmo_tc  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Fixed-priority winner among pending codes (highest index wins)
  always_comb begin
    w_win = 2'd0;
    if (r_pend[3])      w_win = 2'd3;
    else if (r_pend[2]) w_win = 2'd2;
    else if (r_pend[1]) w_win = 2'd1;
  end

  // Mask of codes strictly above the one currently on screen
  always_comb begin
    w_above = 4'b0000;
    case (r_mesg)
      2'd0:    w_above = 4'b1110;
      2'd1:    w_above = 4'b1100;
      2'd2:    w_above = 4'b1000;
      default: w_above = 4'b0000;
    endcase
  end

  assign w_preempt = |(r_pend & w_above);
  assign w_grant   = ((r_state == S_IDLE) && (|r_pend)) ||
                     ((r_state == S_HOLD) && w_preempt);
  assign w_clr     = w_grant ? (4'b0001 << w_win) : 4'b0000;

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic and counter next value
  always_comb begin
    w_next   = r_state;
    w_cnt_nx = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_cnt_nx = '0;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        if (iLCD_DONE || w_tmo_tc) begin
          w_cnt_nx = '0;
          w_next   = S_HOLD;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (w_preempt) begin
          w_next = S_LOAD;
        end else if (w_hold_tc) begin
          w_cnt_nx = '0;
          w_next   = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    oBUSY = (r_state != S_IDLE);
    oMESG = r_mesg;
    oUPD  = r_upd;
    oTMO  = r_tmo;
  end

  // Datapath registers: pending set, counter, message code and strobes
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_pend <= 4'b0001;
      r_cnt  <= '0;
      r_mesg <= 2'd0;
      r_upd  <= 1'b0;
      r_tmo  <= 1'b0;
    end else begin
      // A request arriving on the grant edge re-arms the same code
      r_pend <= (r_pend & ~w_clr) | iREQ;
      r_cnt  <= w_cnt_nx;
      r_upd  <= w_grant;
      r_tmo  <= (r_state == S_WAIT) && !iLCD_DONE && w_tmo_tc;
      if (w_grant) r_mesg <= w_win;
    end
  end

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Scoreboard bench for lcd_msg_scheduler.
// A transaction-level model tracks pending requests and absolute deadlines.
// Each predicted grant and timeout is queued with the cycle it is due on.
// A negedge monitor pops the queue whenever the DUT strobes and compares the result.
module tb_lcd_msg_scheduler;

  localparam int HOLD = 20;
  localparam int TMO  = 10;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [3:0] iREQ = 4'b0000;
  logic       iLCD_DONE = 1'b0;
  logic [1:0] oMESG;
  logic       oUPD;
  logic       oBUSY;
  logic       oTMO;

  lcd_msg_scheduler #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iREQ(iREQ), .iLCD_DONE(iLCD_DONE),
    .oMESG(oMESG), .oUPD(oUPD), .oBUSY(oBUSY), .oTMO(oTMO)
  );

  initial forever #5 iCLK = ~iCLK;

  typedef struct { int code; int cyc; } upd_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  upd_t q_upd[$];
  int   q_tmo[$];

  // Reference model: 0 idle, 1 just granted, 2 awaiting frame, 3 holding
  int m_phase    = 0;
  int m_cur      = 0;
  int m_deadline = 0;
  int m_hold_end = 0;
  bit m_pend[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endfunction

  function automatic int top_pending();
    for (int i = 3; i >= 0; i--) if (m_pend[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int   g;
    upd_t e;
    if (!iRST_N) begin
      m_phase = 0;
      m_cur   = 0;
      m_pend  = '{1'b1, 1'b0, 1'b0, 1'b0};
      q_upd.delete();
      q_tmo.delete();
    end else begin
      cyc++;
      g = -1;
      case (m_phase)
        0: g = top_pending();
        1: begin m_phase = 2; m_deadline = cyc + TMO; end
        2: begin
          if (iLCD_DONE) begin
            m_phase = 3; m_hold_end = cyc + HOLD;
          end else if (cyc == m_deadline) begin
            q_tmo.push_back(cyc);
            m_phase = 3; m_hold_end = cyc + HOLD;
          end
        end
        default: begin
          if (top_pending() > m_cur) g = top_pending();
          else if (cyc == m_hold_end) m_phase = 0;
        end
      endcase
      if (g >= 0) begin
        e.code = g; e.cyc = cyc;
        q_upd.push_back(e);
        m_cur = g; m_pend[g] = 1'b0; m_phase = 1;
      end
      for (int i = 0; i < 4; i++) if (iREQ[i]) m_pend[i] = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge iCLK or negedge iRST_N);
    model_step();
  end

  task automatic monitor_step();
    upd_t e;
    int   t;
    chk("busy", int'(oBUSY), int'(m_phase != 0));
    chk("mesg", int'(oMESG), m_cur);
    if (oUPD) begin
      if (q_upd.size() == 0) chk("upd_unexpected", 1, 0);
      else begin
        e = q_upd.pop_front();
        chk("upd_code", int'(oMESG), e.code);
        chk("upd_cycle", cyc, e.cyc);
      end
    end else if (q_upd.size() > 0 && q_upd[0].cyc <= cyc) begin
      e = q_upd.pop_front();
      chk("upd_missing", 0, 1);
    end
    if (oTMO) begin
      if (q_tmo.size() == 0) chk("tmo_unexpected", 1, 0);
      else begin
        t = q_tmo.pop_front();
        chk("tmo_cycle", cyc, t);
      end
    end else if (q_tmo.size() > 0 && q_tmo[0] <= cyc) begin
      t = q_tmo.pop_front();
      chk("tmo_missing", 0, 1);
    end
  endtask

  initial forever begin
    @(negedge iCLK);
    monitor_step();
  end

  task automatic tick(input logic [3:0] req, input logic done);
    iREQ = req; iLCD_DONE = done;
    @(posedge iCLK); #1;
    iREQ = 4'b0000; iLCD_DONE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(4'b0000, 1'b0);
  endtask

  task automatic bound_fail(input string name, input int ph);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired, phase %0d", name, ph);
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int k = 0;
    while (m_phase != ph && k < budget) begin tick(4'b0000, 1'b0); k++; end
    if (m_phase != ph) bound_fail("wait_phase", m_phase);
  endtask

  // Drive frame completion for every write until the scheduler goes idle
  task automatic serve_to_idle(input int budget);
    int k = 0;
    while (m_phase != 0 && k < budget) begin
      if (m_phase == 2) begin idle(2); tick(4'b0000, 1'b1); end
      else tick(4'b0000, 1'b0);
      k++;
    end
    if (m_phase != 0) bound_fail("serve_to_idle", m_phase);
  endtask

  task automatic do_reset(input int n);
    iRST_N = 1'b0;
    #1;
    chk("rst_mesg", int'(oMESG), 0);
    chk("rst_upd",  int'(oUPD), 0);
    chk("rst_busy", int'(oBUSY), 0);
    chk("rst_tmo",  int'(oTMO), 0);
    repeat (n) @(posedge iCLK);
    #1 iRST_N = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge iCLK); #1;
    do_reset(3);

    // Post-reset Off refresh, then a full hold
    wait_phase(2, 10);
    idle(5);
    tick(4'b0000, 1'b1);
    wait_phase(0, 100);

    // Priority 2 over 1, then 1 after hold; low request waits; 3 preempts
    tick(4'b0110, 1'b0);
    serve_to_idle(0);
    wait_phase(2, 10);  idle(1); tick(4'b0000, 1'b1);
    wait_phase(2, 60);  idle(1); tick(4'b0000, 1'b1);
    wait_phase(3, 10);
    idle(3);
    tick(4'b0001, 1'b0);
    idle(3);
    tick(4'b1000, 1'b0);
    serve_to_idle(400);

    // No preemption while a frame is still being written
    tick(4'b0001, 1'b0);
    wait_phase(2, 10);
    tick(4'b1000, 1'b0);
    idle(3);
    tick(4'b0000, 1'b1);
    serve_to_idle(400);

    // Timeout with a late, ignored done
    tick(4'b0100, 1'b0);
    wait_phase(2, 10);
    idle(14);
    tick(4'b0000, 1'b1);
    wait_phase(0, 100);

    // Reset in hold of code 3 with a pending repeat of 3
    tick(4'b1000, 1'b0);
    wait_phase(2, 10); idle(1); tick(4'b0000, 1'b1);
    wait_phase(3, 10);
    tick(4'b1000, 1'b0);
    idle(2);
    do_reset(2);
    serve_to_idle(400);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      logic       d;
      r = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      d = ((m_phase == 2) && ($urandom_range(0, 5) == 0)) || ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 999) == 0) do_reset($urandom_range(1, 3));
      else tick(r, d);
    end
    serve_to_idle(2000);
    idle(5);

    chk("upd_queue_empty", q_upd.size(), 0);
    chk("tmo_queue_empty", q_tmo.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_msg_scheduler.md
Name: lcd_msg_scheduler

Overview:
- Sequences and arbitrates the LCD message-select path for the control center.
- Up to four requesters (status Off, status On, Alarm, Danger) post display requests; the block grants one, drives the 2-bit message code and an update strobe to the LCD writer, and waits for frame completion.
- Enforces a minimum on-screen hold time, with higher-priority preemption during hold.
- Sits between the alarm FSM/keypad logic and the LCD top-level message input.

Parameters:
- HOLD_CYCLES, 50000000, minimum display time in iCLK cycles after frame completion (1 s at 50 MHz); must be ≥ 2.
- TIMEOUT_CYCLES, 1000000, maximum wait for iLCD_DONE after an update strobe (20 ms); must be ≥ 2.
- CNT_W, 26, shared counter width; must hold max(HOLD_CYCLES, TIMEOUT_CYCLES) − 1.

Ports:
- iCLK  in  1  system clock, 50 MHz.
- iRST_N  in  1  asynchronous active-low reset.
- iREQ  in  4  one-cycle request pulses; bit i requests message code i (0 Off, 1 On, 2 Alarm, 3 Danger).
- iLCD_DONE  in  1  one-cycle pulse from the LCD writer: frame fully written.
- oMESG  out  2  message code to the LCD top level.
- oUPD  out  1  one-cycle strobe: oMESG changed, writer must refresh.
- oBUSY  out  1  high whenever state ≠ IDLE.
- oTMO  out  1  one-cycle pulse: iLCD_DONE timeout occurred.

Behaviour:
- Reset (async assert, sync release to the first edge): state = IDLE, oMESG = 0, oUPD = 0, oTMO = 0, counter = 0, current code = 0, pend = 4'b0001. The Off screen is therefore refreshed automatically after reset.
- Pending register pend[3:0]:
  - iREQ[i] sets pend[i].
  - A grant of code g clears pend[g].
  - If iREQ[g] and the grant of g occur on the same edge, set wins; pend[g] stays 1 and g is shown again later.
  - Repeated requests for an already-pending code are absorbed; no queueing depth.
- Arbitration: fixed priority, highest index wins (3 > 2 > 1 > 0). Arbitration uses the registered pend, so a request takes effect one edge after it is sampled.
- IDLE:
  - If pend ≠ 0: go to LOAD; oMESG <= winner; current <= winner; oUPD <= 1; clear pend[winner].
  - Otherwise remain in IDLE; oMESG holds its value.
- LOAD (1 cycle): oUPD <= 0; counter <= 0; go to WAIT_DONE.
- WAIT_DONE:
  - No preemption; pend keeps accumulating.
  - On iLCD_DONE = 1: counter <= 0; go to HOLD.
  - Otherwise, when counter = TIMEOUT_CYCLES − 1: oTMO <= 1 for one cycle; counter <= 0; go to HOLD.
  - Otherwise counter increments.
  - iLCD_DONE in any other state is ignored.
- HOLD:
  - If any pend[j] = 1 with j > current: preempt; perform the IDLE grant actions for the winner and go directly to LOAD.
  - Else if counter = HOLD_CYCLES − 1: go to IDLE.
  - Else counter increments.
  - Equal- or lower-priority requests wait for hold expiry.
- Latency: iREQ sampled at edge k → pend set at k → grant at k+1 → oUPD high for exactly the cycle between k+1 and k+2, with oMESG valid from k+1. Edge k+1 is the earliest possible grant, when the FSM is already in IDLE.
- oMESG is stable from LOAD until the next grant; it never changes without an oUPD strobe in the same cycle.
- Counter never wraps; compares use ==, and the counter is cleared on every state entry that uses it.
- Asserting reset mid-operation immediately returns all outputs and state to the reset values and discards pending requests except the reset-default pend[0].

Test Plan:
- Post-reset refresh: release iRST_N, no requests → oUPD pulse with oMESG = 0 at the second edge; drive iLCD_DONE 5 cycles later → HOLD_CYCLES (test value 20) cycles of oBUSY = 1, then oBUSY = 0.
- Priority: pulse iREQ = 4'b0110 in IDLE → oMESG = 2 with oUPD two edges after sampling; after that hold expires → oMESG = 1 with oUPD.
- Preemption: while in HOLD showing code 1, pulse iREQ[3] → oUPD with oMESG = 3 on the next edge; hold restarts after iLCD_DONE. A pulse of iREQ[0] during HOLD of code 1 → no grant until hold expiry.
- No preemption in WAIT_DONE: pulse iREQ[3] before iLCD_DONE while code 0 is being written → oMESG stays 0 until iLCD_DONE, then HOLD preempts next edge → oMESG = 3.
- Timeout: withhold iLCD_DONE with TIMEOUT_CYCLES = 10 → oTMO single pulse 10 cycles after LOAD, FSM enters HOLD; a late iLCD_DONE is ignored.
- Reset mid-hold: assert iRST_N low in HOLD with pend = 4'b1000 → oMESG = 0, oUPD = 0, oBUSY = 0 immediately; after release, the code 0 refresh occurs and code 3 is not shown.
